// File: rtl/cpu_pkg.sv
// Shared definitions for the 2DECA5 sequencer and control decoder:
// opcodes, one-hot phase encodings and ARM condition codes.
package cpu_pkg;

  // Opcodes seen on the IR nibble C
  localparam logic [3:0] OP_STP     = 4'b0111;
  localparam logic [3:0] OP_LSL     = 4'b1001;
  localparam logic [3:0] OP_LSR     = 4'b1010;
  localparam logic [1:0] ARM_PREFIX = 2'b11;

  // One-hot phase vector; the sequencer state is this register directly
  typedef enum logic [2:0] {
    Q_HALT  = 3'b000,
    Q_EXEC1 = 3'b001,
    Q_EXEC2 = 3'b010,
    Q_FETCH = 3'b100
  } phase_t;

  // ARM condition selectors (C[1:0])
  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_MI = 2'b01;
  localparam logic [1:0] COND_EQ = 2'b10;
  localparam logic [1:0] COND_NE = 2'b11;

  // True when the selected condition holds for the given flags
  function automatic logic cond_true(input logic [1:0] sel,
                                     input logic mi, input logic eq);
    logic hit;
    unique case (sel)
      COND_AL: hit = 1'b1;
      COND_MI: hit = mi;
      COND_EQ: hit = eq;
      default: hit = ~eq;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cpu_sequencer_edge_detect.sv
// Registered rising-edge detector. The history flop resets to 0, so a
// level already high when reset releases is reported as an edge.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Remember the previous sample of the input level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer: produces the one-hot phase vector Q, the
// conditional-skip flag and halt status, and counts retired instructions.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       C,
  input  logic             MI,
  input  logic             EQ,
  input  logic             run,
  input  logic             step,
  output logic [2:0]       Q,
  output logic             skipff,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  phase_t             q_reg, q_next;
  logic               stepping_reg, stepping_next;
  logic               skip_reg, skip_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               run_rise;
  logic               retire;
  logic               is_shift;
  logic               is_arm;
  logic               stp_halt;
  logic               end_to_halt;

  edge_detect u_run_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (run),
    .rise  (run_rise)
  );

  // State registers: phase, single-step flag, skip flag, retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg        <= Q_HALT;
      stepping_reg <= 1'b0;
      skip_reg     <= 1'b0;
      count_reg    <= '0;
    end else begin
      q_reg        <= q_next;
      stepping_reg <= stepping_next;
      skip_reg     <= skip_next;
      count_reg    <= count_next;
    end
  end

  // Next-phase selection plus retire-time updates of count and skip
  always_comb begin
    q_next        = q_reg;
    stepping_next = stepping_reg;
    skip_next     = skip_reg;
    count_next    = count_reg;
    retire        = 1'b0;
    is_shift      = (C == OP_LSL) || (C == OP_LSR);
    is_arm        = (C[3:2] == ARM_PREFIX);
    stp_halt      = (C == OP_STP) && !skip_reg;
    end_to_halt   = !run || stepping_reg;

    unique case (q_reg)
      Q_HALT: begin
        if (run_rise || step) begin
          q_next        = Q_FETCH;
          stepping_next = step & ~run_rise;
        end
      end
      Q_FETCH: q_next = Q_EXEC1;
      Q_EXEC1: begin
        // Shifts take EXEC2 even when skipped; a skipped STP does not halt
        if (is_shift) begin
          q_next = Q_EXEC2;
        end else begin
          retire = 1'b1;
          q_next = (stp_halt || end_to_halt) ? Q_HALT : Q_FETCH;
        end
      end
      Q_EXEC2: begin
        retire = 1'b1;
        q_next = end_to_halt ? Q_HALT : Q_FETCH;
      end
      default: q_next = Q_HALT;
    endcase

    if (retire) begin
      count_next    = count_reg + CNT_W'(1);
      stepping_next = 1'b0;
      // A skipped ARM instruction never arms the skip for its successor
      skip_next     = (is_arm && !skip_reg) ? ~cond_true(C[1:0], MI, EQ) : 1'b0;
    end
  end

  assign Q           = q_reg;
  assign skipff      = skip_reg;
  assign halted      = (q_reg == Q_HALT);
  assign instr_count = count_reg;

endmodule
